// File: rtl/temp_pkg.sv
// Shared constants, FSM state type and saturation helper for the IR temperature converter.
package temp_pkg;

    localparam int RAW_W     = 16;
    localparam int VAL_W     = 15;
    localparam int DIFF_W    = 17;
    localparam int DIV_W     = 16;
    localparam int TEMP_W    = 8;
    localparam int AVG_DEPTH = 4;
    localparam int SUM_W     = 10;

    localparam int OFFSET_RAW_DEF = 13658;
    localparam int DIVISOR_DEF    = 50;

    localparam logic [DIV_W-1:0] SAT_LIMIT = 16'd255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Negative offsets clamp to 0 degC; anything past the 8-bit range pins at 255.
    function automatic logic [TEMP_W-1:0] saturate(input logic underflow,
                                                   input logic [DIV_W-1:0] q);
        if (underflow) begin
            return '0;
        end
        if (q > SAT_LIMIT) begin
            return SAT_LIMIT[TEMP_W-1:0];
        end
        return q[TEMP_W-1:0];
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Latency: start edge loads operands, then W iteration edges; quotient final after the W-th.
// Backpressure: none; a new start simply restarts the division.
module seq_divider
    import temp_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);
    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     quo_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     dsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W:0]       shifted;
    logic [W-1:0]     sub;
    logic             fits;

    // Remainder is always below the divisor, so the W-bit wrapped difference is exact.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        fits    = (shifted >= {1'b0, dsr_q});
        sub     = shifted[W-1:0] - dsr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
            cnt_q <= CNT_W'(W);
        end else if (cnt_q != '0) begin
            quo_q <= {quo_q[W-2:0], fits};
            rem_q <= fits ? sub : shifted[W-1:0];
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // High during the cycle whose closing edge performs the final iteration.
    assign done     = (cnt_q == CNT_W'(1));
    assign quotient = quo_q;

endmodule

// File: rtl/temp_converter.sv
// Converts raw IR sensor words to integer degC; TEMP_AVG_EN adds a 4-sample running mean.
// Latency: fixed 18 edges accept-to-out_valid (19 with TEMP_AVG_EN) on every path.
// Backpressure: in_ready only in IDLE; in_valid while busy is dropped, never queued.
module temp_converter
    import temp_pkg::*;
#(
    parameter int OFFSET_RAW = OFFSET_RAW_DEF,
    parameter int DIVISOR    = DIVISOR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RAW_W-1:0]  raw_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [TEMP_W-1:0] temperature,
    output logic              out_valid,
    output logic              err
);
    localparam logic [DIFF_W-1:0] OFFSET_EXT = DIFF_W'(OFFSET_RAW);
    localparam logic [DIV_W-1:0]  DIVISOR_W  = DIV_W'(DIVISOR);

    state_t            state_q;
    state_t            state_d;
    logic [RAW_W-1:0]  raw_q;
    logic              uflow_q;
    logic [DIFF_W-1:0] diff;
    logic [DIV_W-1:0]  dividend;
    logic [DIV_W-1:0]  quotient;
    logic              div_start;
    logic              div_done;
    logic              finish;
    logic              sample_err;
    logic [TEMP_W-1:0] sat_result;
    logic [TEMP_W-1:0] new_temp;

    assign in_ready   = (state_q == IDLE);
    assign sample_err = raw_q[RAW_W-1];

    // Underflowing samples still run the divider on zero so every path has equal latency.
    assign diff       = {{(DIFF_W-VAL_W){1'b0}}, raw_q[VAL_W-1:0]} - OFFSET_EXT;
    assign dividend   = diff[DIFF_W-1] ? '0 : diff[DIV_W-1:0];
    assign sat_result = saturate(uflow_q, quotient);

    seq_divider #(
        .W (DIV_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (DIVISOR_W),
        .done     (div_done),
        .quotient (quotient)
    );

`ifdef TEMP_AVG_EN
    logic              avg_stage_q;
    logic              win_init_q;
    logic [TEMP_W-1:0] win_q [AVG_DEPTH];
    logic [SUM_W-1:0]  win_sum;

    // DONE spans two cycles: the first loads the window, the second publishes its mean.
    assign finish = (state_q == DONE) && avg_stage_q;

    always_comb begin
        win_sum = '0;
        for (int i = 0; i < AVG_DEPTH; i++) begin
            win_sum = win_sum + SUM_W'(win_q[i]);
        end
        new_temp = TEMP_W'(win_sum >> 2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avg_stage_q <= 1'b0;
            win_init_q  <= 1'b0;
            for (int i = 0; i < AVG_DEPTH; i++) begin
                win_q[i] <= '0;
            end
        end else if (state_q == DONE) begin
            avg_stage_q <= !avg_stage_q;
            if (!avg_stage_q && !sample_err) begin
                win_init_q <= 1'b1;
                for (int i = 0; i < AVG_DEPTH - 1; i++) begin
                    win_q[i] <= win_init_q ? win_q[i+1] : sat_result;
                end
                win_q[AVG_DEPTH-1] <= sat_result;
            end
        end
    end
`else
    assign finish   = (state_q == DONE);
    assign new_temp = sat_result;
`endif

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                div_start = 1'b1;
                state_d   = DIVIDE;
            end
            DIVIDE: begin
                if (div_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (finish) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            raw_q       <= '0;
            uflow_q     <= 1'b0;
            temperature <= '0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= finish;
            err       <= finish && sample_err;
            if (in_ready && in_valid) begin
                raw_q <= raw_in;
            end
            if (state_q == CHECK) begin
                uflow_q <= diff[DIFF_W-1];
            end
            // Error samples report but leave the displayed value untouched.
            if (finish && !sample_err) begin
                temperature <= new_temp;
            end
        end
    end

endmodule

// File: tb/tb_temp_converter.sv
// Scoreboard bench for temp_converter; expected results are queued at each accepting edge.
module tb_temp_converter;

    localparam int OFF  = 13658;
    localparam int DIVR = 50;
`ifdef TEMP_AVG_EN
    localparam int LAT = 19;
    localparam logic [7:0] EXP_UNDER = 8'd19;
    localparam logic [7:0] EXP_SAT   = 8'd76;
    localparam logic [7:0] EXP_ERR   = 8'd76;
    localparam logic [7:0] EXP_LAST  = 8'd25;
`else
    localparam int LAT = 18;
    localparam logic [7:0] EXP_UNDER = 8'd0;
    localparam logic [7:0] EXP_SAT   = 8'd255;
    localparam logic [7:0] EXP_ERR   = 8'd26;
    localparam logic [7:0] EXP_LAST  = 8'd40;
`endif
    localparam int SPACE = LAT + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] raw_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  temperature;
    logic        out_valid;
    logic        err;

    temp_converter dut (
        .clk         (clk),
        .reset       (reset),
        .raw_in      (raw_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .temperature (temperature),
        .out_valid   (out_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] temp;
        logic       e;
    } exp_t;

    exp_t       sb[$];
    int         acc_q[$];
    logic [7:0] obs_q[$];
    int         checks   = 0;
    int         errors   = 0;
    int         edge_n   = 0;
    int         ov_count = 0;
    logic [7:0] m_temp   = 8'd0;
`ifdef TEMP_AVG_EN
    logic [7:0] m_win [4];
    bit         m_init = 1'b0;
`endif

    function automatic logic [7:0] ref_sat(input logic [15:0] r);
        int v;
        v = int'(r[14:0]);
        if (v < OFF) return 8'd0;
        v = (v - OFF) / DIVR;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    always @(posedge clk) edge_n++;

    // Monitor: pop and compare on out_valid, push model result for the coming accept edge.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [7:0] t;
        int         s;
        if (reset === 1'b1) begin
            sb.delete();
            m_temp = 8'd0;
`ifdef TEMP_AVG_EN
            m_init = 1'b0;
`endif
        end else begin
            if (out_valid === 1'b1) begin
                ov_count++;
                obs_q.push_back(temperature);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid edge=%0d temperature=%0d", edge_n, temperature);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (edge_n !== e.due) begin
                        errors++;
                        $display("FAIL latency edge=%0d required=%0d", edge_n, e.due);
                    end
                    checks++;
                    if (temperature !== e.temp) begin
                        errors++;
                        $display("FAIL temperature got=%0d required=%0d", temperature, e.temp);
                    end
                    checks++;
                    if (err !== e.e) begin
                        errors++;
                        $display("FAIL err got=%b required=%b", err, e.e);
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                t = ref_sat(raw_in);
                if (!raw_in[15]) begin
`ifdef TEMP_AVG_EN
                    if (!m_init) begin
                        for (int i = 0; i < 4; i++) m_win[i] = t;
                        m_init = 1'b1;
                    end else begin
                        for (int i = 0; i < 3; i++) m_win[i] = m_win[i+1];
                        m_win[3] = t;
                    end
                    s = 0;
                    for (int i = 0; i < 4; i++) s += int'(m_win[i]);
                    m_temp = 8'(s / 4);
`else
                    s = 0;
                    m_temp = t;
`endif
                end
                sb.push_back('{due: edge_n + 1 + LAT, temp: m_temp, e: raw_in[15]});
                acc_q.push_back(edge_n + 1);
            end
        end
    end

    task automatic send(input logic [15:0] v);
        int n = 0;
        while (in_ready !== 1'b1 && n < 4 * SPACE) begin
            @(posedge clk); #1; n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_ready_timeout in_ready=%b required=1", in_ready);
        end
        in_valid = 1'b1;
        raw_in   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < LAT + 10) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; raw_in = 16'h7FFF;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        checks++;
        if (temperature !== 8'd0) begin errors++; $display("FAIL reset_temperature got=%0d required=0", temperature); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b required=0", err); end
    endtask

    task automatic test_nominal();
        int hi = 0;
        send(16'd15000);
        // Offer a different sample while busy; it must be neither accepted nor signalled ready.
        for (int i = 0; i < LAT - 2; i++) begin
            in_valid = 1'b1; raw_in = 16'h7FFF;
            if (in_ready !== 1'b0) hi++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (hi !== 0) begin errors++; $display("FAIL busy_in_ready high_cycles=%0d required=0", hi); end
        drain("nominal");
        checks++;
        if (temperature !== 8'd26) begin errors++; $display("FAIL nominal_temp got=%0d required=26", temperature); end
    endtask

    task automatic test_underflow();
        send(16'd13000);
        drain("underflow");
        checks++;
        if (temperature !== EXP_UNDER) begin errors++; $display("FAIL underflow_temp got=%0d required=%0d", temperature, EXP_UNDER); end
    endtask

    task automatic test_saturation();
        send(16'h7FFF);
        drain("saturation");
        checks++;
        if (temperature !== EXP_SAT) begin errors++; $display("FAIL saturation_temp got=%0d required=%0d", temperature, EXP_SAT); end
    endtask

    task automatic test_error();
        send(16'd15000);
        drain("error_prime");
        send(16'h8000);
        drain("error");
        checks++;
        if (temperature !== EXP_ERR) begin errors++; $display("FAIL error_hold_temp got=%0d required=%0d", temperature, EXP_ERR); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        acc_q.delete();
        in_valid = 1'b1; raw_in = 16'd15000;
        while (acc_q.size() < 3 && n < 4 * SPACE) begin
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        checks++;
        if (acc_q.size() < 3) begin
            errors++;
            $display("FAIL b2b_accepts got=%0d required=3", acc_q.size());
        end else begin
            checks++;
            if (acc_q[1] - acc_q[0] !== SPACE) begin errors++; $display("FAIL b2b_spacing1 got=%0d required=%0d", acc_q[1] - acc_q[0], SPACE); end
            checks++;
            if (acc_q[2] - acc_q[1] !== SPACE) begin errors++; $display("FAIL b2b_spacing2 got=%0d required=%0d", acc_q[2] - acc_q[1], SPACE); end
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        int a;
        int base;
        send(16'd15000);
        a = edge_n;
        while (edge_n < a + 7) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got=%b required=1", in_ready); end
        checks++;
        if (temperature !== 8'd0) begin errors++; $display("FAIL abort_temperature got=%0d required=0", temperature); end
        base = ov_count;
        repeat (LAT + 5) @(posedge clk);
        #1;
        checks++;
        if (ov_count !== base) begin errors++; $display("FAIL abort_out_valid pulses=%0d required=0", ov_count - base); end
    endtask

    task automatic test_avg();
        logic [7:0] want [4];
        want[0] = 8'd20; want[1] = 8'd20; want[2] = 8'd20; want[3] = EXP_LAST;
        obs_q.delete();
        for (int i = 0; i < 3; i++) begin
            send(16'd14658);
            drain("avg");
        end
        send(16'd15658);
        drain("avg_last");
        checks++;
        if (obs_q.size() !== 4) begin
            errors++;
            $display("FAIL avg_count got=%0d required=4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_q[i] !== want[i]) begin errors++; $display("FAIL avg_out%0d got=%0d required=%0d", i, obs_q[i], want[i]); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; raw_in = 16'd0;
        test_reset();
        test_nominal();
        test_underflow();
        test_saturation();
        test_error();
        test_back_to_back();
        test_reset_mid();
        test_avg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
